// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared board geometry, full-row constant and the clear-pass
//                state encoding used by the line-clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    // Default board geometry
    localparam int WIDTH_DEF = 12;
    localparam int ROWS_DEF  = 16;

    // A row with every cell occupied
    localparam logic [WIDTH_DEF-1:0] FULL_ROW = '1;

    // Clear-pass sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl
//  Description : Scans the row-register chain bottom-up after a piece locks,
//                commands a one-row shift-down for every full row, and keeps
//                per-pass and saturating running line counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int TOTAL_W = 16
) (
    input  logic                       Clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]    row_addr,
    output logic                       shift_en,
    output logic [$clog2(ROWS)-1:0]    shift_row,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(ROWS+1)-1:0]  lines,
    output logic [TOTAL_W-1:0]         lines_total
);

    localparam int AW    = $clog2(ROWS);
    localparam int LW    = $clog2(ROWS + 1);
    // One spare bit so the saturation test can see the carry out
    localparam int SUM_W = ((TOTAL_W > LW) ? TOTAL_W : LW) + 1;
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;
    localparam logic [AW-1:0]      LAST_ROW  = AW'(ROWS - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     r_q, r_d;
    logic [LW-1:0]     lines_q, lines_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [AW-1:0]     shift_row_q, shift_row_d;
    logic              shift_en_q;
    logic              busy_q;
    logic              done_q;

    logic              row_full;
    logic [SUM_W-1:0]  total_sum;

    assign row_full  = &row_data;
    assign total_sum = SUM_W'(total_q) + SUM_W'(lines_q);

    // Next-state and datapath decisions for the clear pass
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        lines_d     = lines_q;
        total_d     = total_q;
        shift_row_d = shift_row_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = LAST_ROW;
                    lines_d = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (row_full) begin
                    // Row r is overwritten; r stays so the row that falls
                    // into it gets examined on the following SCAN cycle.
                    shift_row_d = r_q;
                    state_d     = SHIFT;
                end else if (r_q == '0) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q - AW'(1);
                end
            end

            SHIFT: begin
                lines_d = lines_q + LW'(1);
                state_d = SCAN;
            end

            DONE: begin
                if (total_sum > SUM_W'(TOTAL_MAX)) begin
                    total_d = TOTAL_MAX;
                end else begin
                    total_d = total_sum[TOTAL_W-1:0];
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered strobes; reset abandons any pass
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            lines_q     <= '0;
            total_q     <= '0;
            shift_row_q <= '0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            lines_q     <= lines_d;
            total_q     <= total_d;
            shift_row_q <= shift_row_d;
            shift_en_q  <= (state_d == SHIFT);
            busy_q      <= (state_d == SCAN) || (state_d == SHIFT);
            done_q      <= (state_d == DONE);
        end
    end

    assign row_addr    = r_q;
    assign shift_en    = shift_en_q;
    assign shift_row   = shift_row_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign lines       = lines_q;
    assign lines_total = total_q;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_clear_ctrl
//  Description : Self-checking bench for line_clear_ctrl with a behavioural
//                row-chain model and a queue of expected shift commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_clear_ctrl;

    localparam int WIDTH   = 12;
    localparam int ROWS    = 16;
    localparam int TOTAL_W = 6;
    localparam int AW      = $clog2(ROWS);
    localparam int LW      = $clog2(ROWS + 1);
    localparam int TMAX    = (1 << TOTAL_W) - 1;

    logic               Clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [WIDTH-1:0]   row_data;
    logic [AW-1:0]      row_addr;
    logic               shift_en;
    logic [AW-1:0]      shift_row;
    logic               busy;
    logic               done;
    logic [LW-1:0]      lines;
    logic [TOTAL_W-1:0] lines_total;

    int tests_run    = 0;
    int tests_failed = 0;

    // Row chain, load port and reference model state
    logic [WIDTH-1:0] board      [ROWS];
    logic [WIDTH-1:0] load_board [ROWS];
    logic [WIDTH-1:0] mb         [ROWS];
    logic             load_en;
    int               sq[$];
    int               exp_n;
    int               exp_done_rel;
    int               exp_total;

    line_clear_ctrl #(
        .WIDTH   (WIDTH),
        .ROWS    (ROWS),
        .TOTAL_W (TOTAL_W)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .start       (start),
        .row_data    (row_data),
        .row_addr    (row_addr),
        .shift_en    (shift_en),
        .shift_row   (shift_row),
        .busy        (busy),
        .done        (done),
        .lines       (lines),
        .lines_total (lines_total)
    );

    always #5 Clk = ~Clk;

    // Behavioural row chain: bulk load, or shift rows 0..shift_row-1 down
    always @(posedge Clk) begin
        if (load_en) begin
            for (int i = 0; i < ROWS; i++) board[i] <= load_board[i];
        end else if (shift_en) begin
            for (int i = 1; i < ROWS; i++)
                if (i <= int'(shift_row)) board[i] <= board[i-1];
            board[0] <= '0;
        end
    end

    assign row_data = board[row_addr];

    task automatic clear_load();
        for (int i = 0; i < ROWS; i++) load_board[i] = '0;
    endtask

    task automatic do_load();
        @(negedge Clk);
        load_en = 1'b1;
        @(negedge Clk);
        load_en = 1'b0;
    endtask

    // Reference algorithm: predicts shift rows, line count, pass length
    task automatic model_pass();
        int r, n, cycles;
        for (int i = 0; i < ROWS; i++) mb[i] = board[i];
        sq.delete();
        r = ROWS - 1;
        n = 0;
        cycles = 0;
        while (1) begin
            cycles++;
            if (&mb[r]) begin
                sq.push_back(r);
                for (int i = ROWS - 1; i >= 1; i--)
                    if (i <= r) mb[i] = mb[i-1];
                mb[0] = '0;
                n++;
                cycles++;
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
        exp_n        = n;
        exp_done_rel = cycles + 1;
        exp_total    = (exp_total + n > TMAX) ? TMAX : exp_total + n;
    endtask

    // One full pass with scoreboard checks; optional stray start at a cycle
    task automatic run_pass(input string name, input int stray_rel);
        int  done_cnt, done_rel, e, bad_rows;
        logic prev_sh, exp_busy;
        model_pass();
        @(negedge Clk);
        start = 1'b1;
        done_cnt = 0;
        done_rel = -1;
        prev_sh  = 1'b0;
        for (int rel = 1; rel <= 4 * ROWS + 10; rel++) begin
            @(negedge Clk);
            start = (rel == stray_rel);
            exp_busy = (rel < exp_done_rel);
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, rel, busy, exp_busy);
            end
            if (shift_en === 1'b1) begin
                tests_run++;
                if (prev_sh !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s back_to_back_shift cycle %0d: got prev=%b expected 0", name, rel, prev_sh);
                end
                tests_run++;
                if (sq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s extra_shift cycle %0d: got shift_row=%0d expected none", name, rel, shift_row);
                end else begin
                    e = sq.pop_front();
                    if (shift_row !== AW'(e)) begin
                        tests_failed++;
                        $display("FAIL %s shift_row cycle %0d: got %0d expected %0d", name, rel, shift_row, e);
                    end
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_rel = rel;
                tests_run++;
                if (shift_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s done_with_shift: got shift_en=%b expected 0", name, shift_en);
                end
                tests_run++;
                if (rel != exp_done_rel) begin
                    tests_failed++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", name, rel, exp_done_rel);
                end
                tests_run++;
                if (lines !== LW'(exp_n)) begin
                    tests_failed++;
                    $display("FAIL %s lines_at_done: got %0d expected %0d", name, lines, exp_n);
                end
            end
            prev_sh = shift_en;
            if (done_rel > 0 && rel >= done_rel + 3) break;
        end
        start = 1'b0;
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s done_count: got %0d expected 1 (timeout if 0)", name, done_cnt);
        end
        tests_run++;
        if (sq.size() != 0) begin
            tests_failed++;
            $display("FAIL %s missing_shifts: got %0d left expected 0", name, sq.size());
        end
        tests_run++;
        if (lines !== LW'(exp_n)) begin
            tests_failed++;
            $display("FAIL %s lines_held: got %0d expected %0d", name, lines, exp_n);
        end
        tests_run++;
        if (lines_total !== TOTAL_W'(exp_total)) begin
            tests_failed++;
            $display("FAIL %s lines_total: got %0d expected %0d", name, lines_total, exp_total);
        end
        bad_rows = 0;
        for (int i = 0; i < ROWS; i++) if (board[i] !== mb[i]) bad_rows++;
        tests_run++;
        if (bad_rows != 0) begin
            tests_failed++;
            $display("FAIL %s final_board: got %0d differing rows expected 0", name, bad_rows);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        load_en = 1'b0;
        exp_total = 0;
        clear_load();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        tests_run++;
        if ({row_addr, shift_en, shift_row, busy, done, lines, lines_total} !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: got addr=%0d sh=%b row=%0d busy=%b done=%b lines=%0d total=%0d expected all 0",
                     row_addr, shift_en, shift_row, busy, done, lines, lines_total);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_empty();
        clear_load();
        do_load();
        run_pass("empty", 0);
    endtask

    task automatic test_single();
        clear_load();
        load_board[15] = 12'hFFF;
        load_board[14] = 12'h0A5;
        do_load();
        run_pass("single", 0);
        tests_run++;
        if (board[15] !== 12'h0A5 || board[0] !== 12'h000) begin
            tests_failed++;
            $display("FAIL single_rows: got r15=%h r0=%h expected 0a5 000", board[15], board[0]);
        end
    endtask

    task automatic test_multi();
        clear_load();
        load_board[15] = 12'hFFF;
        load_board[14] = 12'hFFF;
        load_board[10] = 12'hFFF;
        load_board[9]  = 12'h801;
        do_load();
        run_pass("multi", 0);
        tests_run++;
        if (board[12] !== 12'h801) begin
            tests_failed++;
            $display("FAIL multi_row12: got %h expected 801", board[12]);
        end
    endtask

    task automatic test_full_board(input string name);
        for (int i = 0; i < ROWS; i++) load_board[i] = 12'hFFF;
        do_load();
        run_pass(name, 0);
    endtask

    task automatic test_start_ignored();
        clear_load();
        load_board[15] = 12'hFFF;
        load_board[3]  = 12'h123;
        do_load();
        run_pass("stray_start", 5);
    endtask

    task automatic test_reset_mid();
        clear_load();
        load_board[15] = 12'hFFF;
        load_board[13] = 12'hFFF;
        load_board[12] = 12'h00F;
        do_load();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || lines !== '0 || lines_total !== '0 || shift_en !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got busy=%b lines=%0d total=%0d sh=%b done=%b expected all 0",
                     busy, lines, lines_total, shift_en, done);
        end
        exp_total = 0;
        @(negedge Clk);
        reset_n = 1'b1;
        run_pass("after_reset", 0);
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 5; p++) test_full_board("saturate");
        tests_run++;
        if (lines_total !== TOTAL_W'(TMAX)) begin
            tests_failed++;
            $display("FAIL saturation_final: got %0d expected %0d", lines_total, TMAX);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_multi();
        test_full_board("full_board");
        test_start_ignored();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
